// File: rtl/osc_cfg_pkg.sv
// Shared definitions for the ring-oscillator configuration transmitter.
//   state_t   : FSM states of the transmitter
//   CFG_WIDTH : length of the tile's configuration shifter chain
//   DIV_W     : width of the shift-clock phase counter (DIV up to 255)
package osc_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam int CFG_WIDTH = 12;
  localparam int DIV_W     = 8;

endpackage

// File: rtl/osc_cfg_tick_gen.sv
// Phase counter for the generated shift clock. Each LOW or HIGH phase of
// shift_clk lasts DIV clk cycles; this block counts those cycles and flags
// the first and the last cycle of the current phase.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-high reset
//   active      : FSM is in a LOW or HIGH phase; counter held at 0 otherwise
//   first_cycle : current cycle is the first of its phase
//   last_cycle  : current cycle is the last of its phase
import osc_cfg_pkg::*;

module osc_cfg_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  output logic first_cycle,
  output logic last_cycle
);

  localparam logic [DIV_W-1:0] PHASE_MAX = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] phase_reg;

  // Wrapping at PHASE_MAX lines the counter up with the next phase, so the
  // FSM never has to restart it between LOW and HIGH.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      phase_reg <= '0;
    end else if (!active || phase_reg == PHASE_MAX) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_reg + 1'b1;
    end
  end

  assign first_cycle = (phase_reg == '0);
  assign last_cycle  = (phase_reg == PHASE_MAX);

endmodule

// File: rtl/osc_cfg_shift_tx.sv
// Serial configuration transmitter for the ring-oscillator tile shifter.
// Shifts a parallel word out MSB first on shift_clk/shift_dta, and can
// run a second identical pass that checks the echoed chain tail.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-high reset
//   start       : load request, only looked at in IDLE
//   cfg_word    : word to load, captured with an accepted start
//   verify_en   : captured with start; adds the verify pass
//   echo_in     : chain tail (shifter[WIDTH-1]) from the tile
//   shift_clk   : shift clock to the tile
//   shift_dta   : serial data to the tile
//   busy        : high from acceptance through the done cycle
//   done        : one-cycle end-of-operation pulse
//   verify_ok   : sticky, verify pass matched
//   verify_err  : sticky, verify pass mismatched
import osc_cfg_pkg::*;

module osc_cfg_shift_tx #(
  parameter int WIDTH = CFG_WIDTH,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] cfg_word,
  input  logic             verify_en,
  input  logic             echo_in,
  output logic             shift_clk,
  output logic             shift_dta,
  output logic             busy,
  output logic             done,
  output logic             verify_ok,
  output logic             verify_err
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] word_reg, word_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             ven_reg, ven_next;
  logic             pass_reg, pass_next;
  logic             err_reg, err_next;
  logic             vok_reg, vok_next;
  logic             verr_reg, verr_next;
  logic             dta_reg, dta_next;
  logic             sclk_reg, busy_reg, done_reg;
  logic             first_cycle, last_cycle;
  logic             phase_active;

  assign phase_active = (state_reg == LOW) || (state_reg == HIGH);

  osc_cfg_tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .active     (phase_active),
    .first_cycle(first_cycle),
    .last_cycle (last_cycle)
  );

  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    idx_next   = idx_reg;
    ven_next   = ven_reg;
    pass_next  = pass_reg;
    err_next   = err_reg;
    vok_next   = vok_reg;
    verr_next  = verr_reg;
    dta_next   = dta_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOW;
          word_next  = cfg_word;
          ven_next   = verify_en;
          idx_next   = IDX_MAX;
          pass_next  = 1'b0;
          err_next   = 1'b0;
          vok_next   = 1'b0;
          verr_next  = 1'b0;
          // Data is presented together with the falling shift_clk so it
          // has the whole LOW phase as setup, even with DIV=1.
          dta_next   = cfg_word[IDX_MAX];
        end
      end
      LOW: begin
        // Re-assert the current bit from the latched word; the value is
        // already on the line, so shift_dta never moves inside LOW.
        if (first_cycle) begin
          dta_next = word_reg[idx_reg];
        end
        if (last_cycle) begin
          // The tail is stable here: the tile shifts only on our rising edge.
          if (pass_reg && (echo_in != word_reg[idx_reg])) begin
            err_next = 1'b1;
          end
          state_next = HIGH;
        end
      end
      HIGH: begin
        if (last_cycle) begin
          if (idx_reg != '0) begin
            idx_next   = idx_reg - 1'b1;
            dta_next   = word_reg[idx_reg - 1'b1];
            state_next = LOW;
          end else if (!pass_reg && ven_reg) begin
            pass_next  = 1'b1;
            idx_next   = IDX_MAX;
            dta_next   = word_reg[IDX_MAX];
            state_next = LOW;
          end else begin
            state_next = DONE;
            // Result becomes visible together with the done pulse.
            if (ven_reg) begin
              vok_next  = ~err_reg;
              verr_next = err_reg;
            end
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so shift_clk is glitch-free
  // and still drops immediately on reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      idx_reg   <= '0;
      ven_reg   <= 1'b0;
      pass_reg  <= 1'b0;
      err_reg   <= 1'b0;
      vok_reg   <= 1'b0;
      verr_reg  <= 1'b0;
      dta_reg   <= 1'b0;
      sclk_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      idx_reg   <= idx_next;
      ven_reg   <= ven_next;
      pass_reg  <= pass_next;
      err_reg   <= err_next;
      vok_reg   <= vok_next;
      verr_reg  <= verr_next;
      dta_reg   <= dta_next;
      sclk_reg  <= (state_next == HIGH);
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
    end
  end

  assign shift_clk  = sclk_reg;
  assign shift_dta  = dta_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign verify_ok  = vok_reg;
  assign verify_err = verr_reg;

endmodule

// File: tb/tb_osc_cfg_shift_tx.sv
// Scoreboard bench for osc_cfg_shift_tx. Channel 0 is a DIV=2 instance,
// channel 1 a DIV=1 instance; each drives a 12-bit tile shifter model
// whose tail feeds echo_in. Stimulus pushes expected run results; a
// monitor pops one entry per done pulse and compares.
module tb_osc_cfg_shift_tx;

  typedef struct {
    string       name;
    int          chan;
    int          rises;
    int          busy_cyc;
    int          vok;
    int          verr;
    bit          chk_model;
    logic [11:0] model;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] cfg_word = '0;
  logic        verify_en = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        sclk0, dta0, busy0, done0, vok0, verr0;
  logic        sclk1, dta1, busy1, done1, vok1, verr1;
  logic [11:0] sh0 = '0, sh1 = '0;
  logic        stuck0 = 1'b0;
  logic        echo0, echo1;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  assign echo0 = sh0[11];
  assign echo1 = sh1[11];

  osc_cfg_shift_tx #(.WIDTH(12), .DIV(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cfg_word(cfg_word),
    .verify_en(verify_en), .echo_in(echo0), .shift_clk(sclk0),
    .shift_dta(dta0), .busy(busy0), .done(done0), .verify_ok(vok0),
    .verify_err(verr0));

  osc_cfg_shift_tx #(.WIDTH(12), .DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cfg_word(cfg_word),
    .verify_en(verify_en), .echo_in(echo1), .shift_clk(sclk1),
    .shift_dta(dta1), .busy(busy1), .done(done1), .verify_ok(vok1),
    .verify_err(verr1));

  initial forever #5 clk = ~clk;

  // Tile shifter models: shift on the rising shift_clk, MSB enters first.
  initial forever begin
    @(posedge sclk0);
    sh0 = {sh0[10:0], dta0};
    if (stuck0) sh0[5] = 1'b0;
  end
  initial forever begin
    @(posedge sclk1);
    sh1 = {sh1[10:0], dta1};
  end

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", nm, act, act, expv, expv);
    end
  endtask

  // Monitor: counts rises/busy per channel, checks edge spacing, and
  // scores each done pulse against the queue.
  initial begin : monitor
    int   rises[2];
    int   bcnt[2];
    int   since[2];
    bit   prev[2];
    bit   sc, bz, dn;
    int   vk, ve;
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      rises[c] = 0; bcnt[c] = 0; since[c] = 0; prev[c] = 0;
    end
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        sc = (c == 0) ? sclk0 : sclk1;
        bz = (c == 0) ? busy0 : busy1;
        dn = (c == 0) ? done0 : done1;
        vk = (c == 0) ? int'(vok0) : int'(vok1);
        ve = (c == 0) ? int'(verr0) : int'(verr1);
        if (rst_n) begin
          rises[c] = 0; bcnt[c] = 0; since[c] = 0; prev[c] = 0;
        end else begin
          if (bz) bcnt[c]++;
          since[c]++;
          if (sc && !prev[c]) begin
            if (rises[c] > 0) check($sformatf("rise_spacing_ch%0d", c), since[c], (c == 0) ? 4 : 2);
            rises[c]++;
            since[c] = 0;
          end
          prev[c] = sc;
          if (dn) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_done ch%0d actual=pulse expected=none", c);
            end else begin
              e = exp_q.pop_front();
              check({e.name, "_chan"}, c, e.chan);
              check({e.name, "_rises"}, rises[c], e.rises);
              check({e.name, "_busy_cycles"}, bcnt[c], e.busy_cyc);
              check({e.name, "_verify_ok"}, vk, e.vok);
              check({e.name, "_verify_err"}, ve, e.verr);
              if (e.chk_model) check({e.name, "_model"}, int'((c == 0) ? sh0 : sh1), int'(e.model));
              $display("txn %s ch%0d rises=%0d busy=%0d vok=%0d verr=%0d model=0x%03h",
                       e.name, c, rises[c], bcnt[c], vk, ve, (c == 0) ? sh0 : sh1);
            end
            rises[c] = 0; bcnt[c] = 0;
          end
        end
      end
    end
  end

  task automatic push(input string nm, input int ch, input int r, input int b,
                      input int vk, input int ve, input bit cm, input logic [11:0] m);
    exp_t e;
    e.name = nm; e.chan = ch; e.rises = r; e.busy_cyc = b;
    e.vok = vk; e.verr = ve; e.chk_model = cm; e.model = m;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input int ch, input logic [11:0] w, input logic v);
    @(negedge clk);
    cfg_word = w; verify_en = v;
    if (ch == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  // Returns at the negedge where done is seen.
  task automatic wait_done(input int ch, input string nm);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if ((ch == 0) ? done0 : done1) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done expected=done", nm);
    end
  endtask

  initial begin : stim
    int  r;
    bit  prev;
    repeat (3) @(negedge clk);
    check("rst_shift_clk", int'(sclk0), 0);
    check("rst_shift_dta", int'(dta0), 0);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_verify_ok", int'(vok0), 0);
    check("rst_verify_err", int'(verr0), 0);
    check("rst_busy_div1", int'(busy1), 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Basic load
    push("basic_A5C", 0, 12, 49, 0, 0, 1, 12'hA5C);
    pulse_start(0, 12'hA5C, 1'b0);
    wait_done(0, "basic_A5C");
    repeat (3) @(negedge clk);

    // Verify pass with ideal loopback
    push("verify_3F1", 0, 24, 97, 1, 0, 1, 12'h3F1);
    pulse_start(0, 12'h3F1, 1'b1);
    wait_done(0, "verify_3F1");
    repeat (3) @(negedge clk);

    // Fault detection: shifter[5] stuck-at-0
    stuck0 = 1'b1;
    push("fault_FFF", 0, 24, 97, 0, 1, 0, 12'h000);
    pulse_start(0, 12'hFFF, 1'b1);
    wait_done(0, "fault_FFF");
    repeat (2) @(negedge clk);
    stuck0 = 1'b0;
    check("sticky_verify_err", int'(verr0), 1);
    repeat (2) @(negedge clk);

    // Busy protection
    push("busy_555", 0, 12, 49, 0, 0, 1, 12'h555);
    push("after_done_0A3", 0, 12, 49, 0, 0, 1, 12'h0A3);
    pulse_start(0, 12'h555, 1'b0);
    repeat (8) @(negedge clk);
    pulse_start(0, 12'h000, 1'b0);
    wait_done(0, "busy_555");
    cfg_word = 12'h0A3;
    start0 = 1'b1;                    // sampled in the DONE cycle
    @(negedge clk);
    check("done_cycle_start_ignored", int'(busy0), 0);
    @(negedge clk);                   // sampled again in IDLE
    start0 = 1'b0;
    check("idle_start_accepted", int'(busy0), 1);
    wait_done(0, "after_done_0A3");
    repeat (3) @(negedge clk);

    // Reset in the middle of an operation, during a HIGH phase
    pulse_start(0, 12'h5A5, 1'b0);
    r = 0; prev = 0;
    for (int i = 0; i < 200 && r < 6; i++) begin
      @(negedge clk);
      if (sclk0 && !prev) r++;
      prev = sclk0;
    end
    check("midop_high_before_reset", int'(sclk0), 1);
    rst_n = 1'b1;
    #1;
    check("midop_reset_shift_clk", int'(sclk0), 0);
    check("midop_reset_busy", int'(busy0), 0);
    repeat (3) @(negedge clk);
    check("midop_no_done", int'(done0), 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    push("post_reset_0F0", 0, 12, 49, 0, 0, 1, 12'h0F0);
    pulse_start(0, 12'h0F0, 1'b0);
    wait_done(0, "post_reset_0F0");
    repeat (3) @(negedge clk);

    // DIV=1 corner
    push("div1_801", 1, 12, 25, 0, 0, 1, 12'h801);
    pulse_start(1, 12'h801, 1'b0);
    wait_done(1, "div1_801");
    repeat (4) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
